// File: rtl/mha_pkg.sv
// Definitions shared by the attention tile sequencer and bram_manager:
// matrix-select codes, tile index/count widths and the sequencer state encoding.
package mha_pkg;

   localparam int TILE_IDX_W = 6;
   localparam int TILE_CNT_W = TILE_IDX_W + 1;

   localparam logic [1:0] SEL_Q = 2'b00;
   localparam logic [1:0] SEL_K = 2'b01;
   localparam logic [1:0] SEL_V = 2'b10;
   localparam logic [1:0] SEL_O = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      CALC_REQ,
      CALC_WAIT,
      WR_REQ,
      WR_WAIT,
      FIN
   } state_t;

endpackage

// File: rtl/attn_tile_seq.sv
// Tile sequencer: for each tile, loads Q, K and V from bram_manager, runs the
// compute engine, writes the O tile back, and pulses O_DONE after the last tile.
module attn_tile_seq
   import mha_pkg::*;
#(
   parameter int MAX_TILES = 64
)
(
   input  logic                  I_CLK,
   input  logic                  I_RST_N,
   input  logic                  I_START,
   input  logic [TILE_CNT_W-1:0] I_TILE_NUM,
   input  logic                  I_ABORT,
   input  logic                  I_CALC_DONE,
   input  logic                  I_BRAM_VLD,
   input  logic                  I_BRAM_WR_DONE,
   output logic                  O_BRAM_RD_ENA_PULSE,
   output logic                  O_BRAM_WR_ENA_PULSE,
   output logic [7:0]            O_BRAM_SEL,
   output logic                  O_LOAD_VLD,
   output logic [1:0]            O_LOAD_SEL,
   output logic                  O_CALC_START,
   output logic [TILE_IDX_W-1:0] O_TILE_IDX,
   output logic                  O_BUSY,
   output logic                  O_DONE
);

   localparam logic [TILE_CNT_W-1:0] MAX_CNT = TILE_CNT_W'(MAX_TILES);

   state_t                  state_reg, state_next;
   logic [TILE_IDX_W-1:0]   idx_reg, idx_next;
   logic [1:0]              mat_reg, mat_next;
   logic [TILE_CNT_W-1:0]   cnt_reg, cnt_next;
   logic [7:0]              sel_reg, sel_next;
   logic                    last_tile;

   assign last_tile = ({1'b0, idx_reg} == (cnt_reg - TILE_CNT_W'(1)));

   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         mat_reg   <= SEL_Q;
         cnt_reg   <= '0;
         sel_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         mat_reg   <= mat_next;
         cnt_reg   <= cnt_next;
         sel_reg   <= sel_next;
      end
   end

   always_comb begin
      state_next          = state_reg;
      idx_next            = idx_reg;
      mat_next            = mat_reg;
      cnt_next            = cnt_reg;
      sel_next            = sel_reg;
      O_BRAM_RD_ENA_PULSE = 1'b0;
      O_BRAM_WR_ENA_PULSE = 1'b0;
      O_LOAD_VLD          = 1'b0;
      O_LOAD_SEL          = SEL_Q;
      O_CALC_START        = 1'b0;
      O_DONE              = 1'b0;

      // Abort overrides everything, including a start in the same cycle.
      if (I_ABORT) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (I_START) begin
                  cnt_next   = (I_TILE_NUM > MAX_CNT) ? MAX_CNT : I_TILE_NUM;
                  idx_next   = '0;
                  mat_next   = SEL_Q;
                  state_next = RD_REQ;
               end
            end
            RD_REQ: begin
               // An empty run is detected here so it finishes without any request.
               if (cnt_reg == '0) begin
                  state_next = FIN;
               end else begin
                  O_BRAM_RD_ENA_PULSE = 1'b1;
                  sel_next            = {mat_reg, idx_reg};
                  state_next          = RD_WAIT;
               end
            end
            RD_WAIT: begin
               O_LOAD_VLD = I_BRAM_VLD;
               O_LOAD_SEL = mat_reg;
               if (I_BRAM_VLD) begin
                  case (mat_reg)
                     SEL_Q:   begin mat_next = SEL_K; state_next = RD_REQ; end
                     SEL_K:   begin mat_next = SEL_V; state_next = RD_REQ; end
                     default: state_next = CALC_REQ;
                  endcase
               end
            end
            CALC_REQ: begin
               O_CALC_START = 1'b1;
               state_next   = CALC_WAIT;
            end
            CALC_WAIT: begin
               if (I_CALC_DONE) state_next = WR_REQ;
            end
            WR_REQ: begin
               O_BRAM_WR_ENA_PULSE = 1'b1;
               sel_next            = {SEL_O, idx_reg};
               state_next          = WR_WAIT;
            end
            WR_WAIT: begin
               if (I_BRAM_WR_DONE) begin
                  if (last_tile) begin
                     state_next = FIN;
                  end else begin
                     idx_next   = idx_reg + TILE_IDX_W'(1);
                     mat_next   = SEL_Q;
                     state_next = RD_REQ;
                  end
               end
            end
            FIN: begin
               O_DONE     = 1'b1;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // sel_next only differs from sel_reg in a request cycle, so the select is
   // valid with the pulse and then held until the next request.
   assign O_BRAM_SEL = sel_next;
   assign O_TILE_IDX = idx_reg;
   assign O_BUSY     = (state_reg != IDLE);

endmodule

// File: tb/tb_attn_tile_seq.sv
// Directed bench for attn_tile_seq with a small bram/compute responder model.
module tb_attn_tile_seq;

   logic       I_CLK = 1'b0;
   logic       I_RST_N = 1'b0;
   logic       I_START = 1'b0;
   logic [6:0] I_TILE_NUM = 7'd0;
   logic       I_ABORT = 1'b0;
   logic       I_CALC_DONE = 1'b0;
   logic       I_BRAM_VLD = 1'b0;
   logic       I_BRAM_WR_DONE = 1'b0;
   logic       O_BRAM_RD_ENA_PULSE, O_BRAM_WR_ENA_PULSE;
   logic [7:0] O_BRAM_SEL;
   logic       O_LOAD_VLD;
   logic [1:0] O_LOAD_SEL;
   logic       O_CALC_START;
   logic [5:0] O_TILE_IDX;
   logic       O_BUSY, O_DONE;

   always #5 I_CLK = ~I_CLK;

   attn_tile_seq #(.MAX_TILES(64)) dut (
      .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_START(I_START), .I_TILE_NUM(I_TILE_NUM),
      .I_ABORT(I_ABORT), .I_CALC_DONE(I_CALC_DONE), .I_BRAM_VLD(I_BRAM_VLD),
      .I_BRAM_WR_DONE(I_BRAM_WR_DONE), .O_BRAM_RD_ENA_PULSE(O_BRAM_RD_ENA_PULSE),
      .O_BRAM_WR_ENA_PULSE(O_BRAM_WR_ENA_PULSE), .O_BRAM_SEL(O_BRAM_SEL),
      .O_LOAD_VLD(O_LOAD_VLD), .O_LOAD_SEL(O_LOAD_SEL), .O_CALC_START(O_CALC_START),
      .O_TILE_IDX(O_TILE_IDX), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_rd, n_wr, n_ld, n_calc, n_done, viol, busy_gap;
   int done_cyc, wrdone_cyc, calcdone_cyc, start_cyc, first_rd_cyc;
   int rd_cd, wr_cd, calc_cd, calc_limit;
   logic start_req = 1'b0, abort_req = 1'b0, stray_vld = 1'b0, run_active = 1'b0;
   logic [7:0] rd_sel [256];
   logic [7:0] wr_sel [64];
   int         wr_cyc [64];
   logic [1:0] ld_sel [256];

   task automatic clear_logs();
      n_rd = 0; n_wr = 0; n_ld = 0; n_calc = 0; n_done = 0; viol = 0; busy_gap = 0;
      done_cyc = -1; wrdone_cyc = -1; calcdone_cyc = -1; start_cyc = -1; first_rd_cyc = -1;
      rd_cd = 0; wr_cd = 0; calc_cd = 0; calc_limit = 1000; run_active = 1'b0;
   endtask

   // One clock cycle: drive inputs #1 after the edge, sample outputs #1 later.
   task automatic step();
      @(posedge I_CLK);
      #1;
      cyc++;
      I_START = start_req;  start_req = 1'b0;
      I_ABORT = abort_req;  abort_req = 1'b0;
      I_BRAM_VLD = stray_vld; stray_vld = 1'b0;
      if (rd_cd > 0) begin rd_cd--; if (rd_cd == 0) I_BRAM_VLD = 1'b1; end
      I_BRAM_WR_DONE = 1'b0;
      if (wr_cd > 0) begin wr_cd--; if (wr_cd == 0) begin I_BRAM_WR_DONE = 1'b1; wrdone_cyc = cyc; end end
      I_CALC_DONE = 1'b0;
      if (calc_cd > 0) begin calc_cd--; if (calc_cd == 0) begin I_CALC_DONE = 1'b1; calcdone_cyc = cyc; end end
      #1;
      if (O_BRAM_RD_ENA_PULSE) begin
         if (rd_cd > 0 || wr_cd > 0 || O_BRAM_WR_ENA_PULSE) viol++;
         if (n_rd == 0) first_rd_cyc = cyc;
         if (n_rd < 256) rd_sel[n_rd] = O_BRAM_SEL;
         n_rd++;
         rd_cd = 3;
         $display("cyc %0d: read  sel=%h", cyc, O_BRAM_SEL);
      end
      if (O_BRAM_WR_ENA_PULSE) begin
         if (rd_cd > 0 || wr_cd > 0) viol++;
         if (n_wr < 64) begin wr_sel[n_wr] = O_BRAM_SEL; wr_cyc[n_wr] = cyc; end
         n_wr++;
         wr_cd = 2;
         $display("cyc %0d: write sel=%h", cyc, O_BRAM_SEL);
      end
      if (O_LOAD_VLD) begin
         if (n_ld < 256) ld_sel[n_ld] = O_LOAD_SEL;
         n_ld++;
      end
      if (O_CALC_START) begin
         n_calc++;
         if (n_calc <= calc_limit) calc_cd = 4;
      end
      if (O_DONE) begin
         n_done++; done_cyc = cyc; run_active = 1'b0;
         $display("cyc %0d: done", cyc);
      end else if (run_active && !O_BUSY) begin
         busy_gap++;
      end
   endtask

   task automatic start_run(input logic [6:0] n);
      I_TILE_NUM = n;
      start_req = 1'b1;
      step();
      start_cyc = cyc;
      run_active = 1'b1;
   endtask

   task automatic run_to_done(input int max_cyc);
      int k = 0;
      while (n_done == 0 && k < max_cyc) begin step(); k++; end
      checks++;
      if (n_done == 0) begin
         errors++; $display("FAIL run_to_done: no O_DONE within %0d cycles, required 1", max_cyc);
      end
      repeat (3) step();
   endtask

   task automatic run_to_rd(input int n, input int max_cyc);
      int k = 0;
      while (n_rd < n && k < max_cyc) begin step(); k++; end
      checks++;
      if (n_rd < n) begin errors++; $display("FAIL run_to_rd: reads=%0d required %0d", n_rd, n); end
   endtask

   task automatic run_to_calc(input int n, input int max_cyc);
      int k = 0;
      while (n_calc < n && k < max_cyc) begin step(); k++; end
      checks++;
      if (n_calc < n) begin errors++; $display("FAIL run_to_calc: calc starts=%0d required %0d", n_calc, n); end
   endtask

   task automatic test_reset();
      clear_logs();
      I_RST_N = 1'b0;
      step(); step();
      checks++; if (O_BRAM_SEL !== 8'h00) begin errors++; $display("FAIL reset_sel: got %h required 00", O_BRAM_SEL); end
      checks++; if (O_TILE_IDX !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d required 0", O_TILE_IDX); end
      checks++; if (O_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", O_BUSY); end
      checks++;
      if ({O_BRAM_RD_ENA_PULSE, O_BRAM_WR_ENA_PULSE, O_LOAD_VLD, O_LOAD_SEL, O_CALC_START, O_DONE} !== 7'd0) begin
         errors++; $display("FAIL reset_pulses: got %b required 0000000",
            {O_BRAM_RD_ENA_PULSE, O_BRAM_WR_ENA_PULSE, O_LOAD_VLD, O_LOAD_SEL, O_CALC_START, O_DONE});
      end
      I_RST_N = 1'b1;
      step();
   endtask

   task automatic test_single_tile();
      logic [7:0] exp_rd [3];
      exp_rd[0] = 8'h00; exp_rd[1] = 8'h40; exp_rd[2] = 8'h80;
      clear_logs();
      start_run(7'd1);
      run_to_done(200);
      checks++; if (first_rd_cyc - start_cyc !== 1) begin errors++; $display("FAIL single_first_rd: latency %0d required 1", first_rd_cyc - start_cyc); end
      checks++; if (n_rd !== 3) begin errors++; $display("FAIL single_nrd: got %0d required 3", n_rd); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (rd_sel[i] !== exp_rd[i]) begin errors++; $display("FAIL single_rd_sel%0d: got %h required %h", i, rd_sel[i], exp_rd[i]); end
         checks++; if (ld_sel[i] !== 2'(i)) begin errors++; $display("FAIL single_ld_sel%0d: got %0d required %0d", i, ld_sel[i], i); end
      end
      checks++; if (n_ld !== 3) begin errors++; $display("FAIL single_nld: got %0d required 3", n_ld); end
      checks++; if (n_calc !== 1) begin errors++; $display("FAIL single_ncalc: got %0d required 1", n_calc); end
      checks++; if (n_wr !== 1) begin errors++; $display("FAIL single_nwr: got %0d required 1", n_wr); end
      checks++; if (wr_sel[0] !== 8'hC0) begin errors++; $display("FAIL single_wr_sel: got %h required c0", wr_sel[0]); end
      checks++; if (wr_cyc[0] - calcdone_cyc !== 1) begin errors++; $display("FAIL single_wr_after_calc: gap %0d required 1", wr_cyc[0] - calcdone_cyc); end
      checks++; if (done_cyc - wrdone_cyc !== 1) begin errors++; $display("FAIL single_done_lat: gap %0d required 1", done_cyc - wrdone_cyc); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL single_ndone: got %0d required 1", n_done); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL single_overlap: got %0d required 0", viol); end
      checks++; if (O_BUSY !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b required 0", O_BUSY); end
   endtask

   task automatic test_three_tiles();
      clear_logs();
      start_run(7'd3);
      run_to_done(400);
      checks++; if (n_rd !== 9) begin errors++; $display("FAIL three_nrd: got %0d required 9", n_rd); end
      checks++; if (n_wr !== 3) begin errors++; $display("FAIL three_nwr: got %0d required 3", n_wr); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (wr_sel[i] !== (8'hC0 + 8'(i))) begin errors++; $display("FAIL three_wr_sel%0d: got %h required %h", i, wr_sel[i], 8'hC0 + 8'(i)); end
      end
      checks++; if (rd_sel[7] !== 8'h42) begin errors++; $display("FAIL three_rd_sel7: got %h required 42", rd_sel[7]); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL three_ndone: got %0d required 1", n_done); end
      checks++; if (busy_gap !== 0) begin errors++; $display("FAIL three_busy: idle cycles %0d required 0", busy_gap); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL three_overlap: got %0d required 0", viol); end
   endtask

   task automatic test_boundary();
      clear_logs();
      start_run(7'd0);
      run_to_done(20);
      checks++; if (done_cyc - start_cyc !== 2) begin errors++; $display("FAIL zero_done_lat: got %0d required 2", done_cyc - start_cyc); end
      checks++; if (n_rd + n_wr !== 0) begin errors++; $display("FAIL zero_requests: got %0d required 0", n_rd + n_wr); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL zero_ndone: got %0d required 1", n_done); end
      clear_logs();
      start_run(7'd100);
      run_to_done(3000);
      checks++; if (n_wr !== 64) begin errors++; $display("FAIL clamp_nwr: got %0d required 64", n_wr); end
      checks++; if (wr_sel[63] !== 8'hFF) begin errors++; $display("FAIL clamp_last_sel: got %h required ff", wr_sel[63]); end
      checks++; if (n_rd !== 192) begin errors++; $display("FAIL clamp_nrd: got %0d required 192", n_rd); end
   endtask

   task automatic test_abort();
      clear_logs();
      calc_limit = 1;
      start_run(7'd3);
      run_to_calc(2, 300);
      step();
      abort_req = 1'b1;
      run_active = 1'b0;
      step();
      step();
      checks++; if (O_BUSY !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b required 0", O_BUSY); end
      repeat (15) step();
      checks++; if (n_wr !== 1) begin errors++; $display("FAIL abort_nwr: got %0d required 1", n_wr); end
      checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_done: got %0d required 0", n_done); end
      clear_logs();
      start_run(7'd1);
      run_to_done(200);
      checks++; if (rd_sel[0] !== 8'h00) begin errors++; $display("FAIL abort_restart_rd: got %h required 00", rd_sel[0]); end
      checks++; if (wr_sel[0] !== 8'hC0) begin errors++; $display("FAIL abort_restart_wr: got %h required c0", wr_sel[0]); end
   endtask

   task automatic test_stray();
      clear_logs();
      start_run(7'd2);
      run_to_calc(1, 200);
      stray_vld = 1'b1;
      I_TILE_NUM = 7'd5;
      start_req = 1'b1;
      run_to_done(400);
      checks++; if (n_ld !== 6) begin errors++; $display("FAIL stray_nld: got %0d required 6", n_ld); end
      checks++; if (n_rd !== 6) begin errors++; $display("FAIL stray_nrd: got %0d required 6", n_rd); end
      checks++; if (n_wr !== 2) begin errors++; $display("FAIL stray_nwr: got %0d required 2", n_wr); end
      checks++; if (wr_sel[1] !== 8'hC1) begin errors++; $display("FAIL stray_wr_sel: got %h required c1", wr_sel[1]); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL stray_ndone: got %0d required 1", n_done); end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      start_run(7'd2);
      run_to_rd(5, 300);
      step();
      checks++; if (O_BUSY !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b required 1", O_BUSY); end
      #1;
      I_RST_N = 1'b0;
      #1;
      checks++; if (O_BRAM_SEL !== 8'h00) begin errors++; $display("FAIL midrst_sel: got %h required 00", O_BRAM_SEL); end
      checks++; if (O_TILE_IDX !== 6'd0) begin errors++; $display("FAIL midrst_idx: got %0d required 0", O_TILE_IDX); end
      checks++; if (O_BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", O_BUSY); end
      checks++;
      if ({O_BRAM_RD_ENA_PULSE, O_BRAM_WR_ENA_PULSE, O_LOAD_VLD, O_LOAD_SEL, O_CALC_START, O_DONE} !== 7'd0) begin
         errors++; $display("FAIL midrst_pulses: got %b required 0000000",
            {O_BRAM_RD_ENA_PULSE, O_BRAM_WR_ENA_PULSE, O_LOAD_VLD, O_LOAD_SEL, O_CALC_START, O_DONE});
      end
      rd_cd = 0; wr_cd = 0; calc_cd = 0; run_active = 1'b0;
      step(); step();
      I_RST_N = 1'b1;
      repeat (20) step();
      checks++; if (n_done !== 0) begin errors++; $display("FAIL midrst_done: got %0d required 0", n_done); end
      checks++; if (n_rd !== 5) begin errors++; $display("FAIL midrst_nrd: got %0d required 5", n_rd); end
      checks++; if (O_BUSY !== 1'b0) begin errors++; $display("FAIL midrst_wait: busy %b required 0", O_BUSY); end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_three_tiles();
      test_boundary();
      test_abort();
      test_stray();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/attn_tile_seq.md
ATTN_TILE_SEQ -- requirements
Module: attn_tile_seq

Interface
REQ-001 SHALL have parameter MAX_TILES, default 64, the number of tiles per matrix in BRAM.
REQ-002 SHALL have port I_CLK, input, 1 bit, the single clock for all logic.
REQ-003 SHALL have port I_RST_N, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 SHALL have port I_START, input, 1 bit, a one-cycle pulse that starts a run.
REQ-005 SHALL have port I_TILE_NUM, input, 7 bits, the tile count for the run, sampled on I_START.
REQ-006 SHALL have port I_ABORT, input, 1 bit, a synchronous abort with the highest priority.
REQ-007 SHALL have port I_CALC_DONE, input, 1 bit, a pulse from the compute engine when the tile is finished.
REQ-008 SHALL have port I_BRAM_VLD, input, 1 bit, the bram_manager read-data-valid pulse.
REQ-009 SHALL have port I_BRAM_WR_DONE, input, 1 bit, the bram_manager write-complete pulse.
REQ-010 SHALL have port O_BRAM_RD_ENA_PULSE, output, 1 bit, a one-cycle read request to bram_manager.
REQ-011 SHALL have port O_BRAM_WR_ENA_PULSE, output, 1 bit, a one-cycle write request to bram_manager.
REQ-012 SHALL have port O_BRAM_SEL, output, 8 bits: [7:6] selects the matrix (00 Q, 01 K, 10 V, 11 O) and [5:0] is the tile index.
REQ-013 SHALL have port O_LOAD_VLD, output, 1 bit, the strobe on which the compute engine captures bram_manager O_MAT.
REQ-014 SHALL have port O_LOAD_SEL, output, 2 bits, naming the matrix being loaded (Q, K or V).
REQ-015 SHALL have port O_CALC_START, output, 1 bit, a one-cycle pulse that starts compute on the loaded tile.
REQ-016 SHALL have port O_TILE_IDX, output, 6 bits, the current tile index.
REQ-017 SHALL have port O_BUSY, output, 1 bit, high while the state is not IDLE.
REQ-018 SHALL have port O_DONE, output, 1 bit, a one-cycle pulse at the end of a run.

Function
REQ-019 SHALL implement the FSM states IDLE, RD_REQ, RD_WAIT, CALC_REQ, CALC_WAIT, WR_REQ, WR_WAIT and FIN.
REQ-020 SHALL, on I_START in IDLE, latch min(I_TILE_NUM, MAX_TILES), clear the tile index and the Q/K/V counter, and go to RD_REQ.
REQ-021 SHALL, in RD_REQ, assert O_BRAM_RD_ENA_PULSE for exactly one cycle with O_BRAM_SEL = {mat, idx}, then go to RD_WAIT.
- First read pulse is the cycle after I_START.
REQ-022 SHALL, in RD_WAIT, drive O_LOAD_VLD = I_BRAM_VLD combinationally with O_LOAD_SEL = mat (same cycle as the data).
- The cycle after I_BRAM_VLD: go to RD_REQ with the next mat (Q->K->V); after V, go to CALC_REQ.
REQ-023 SHALL, in CALC_REQ, pulse O_CALC_START for one cycle, then go to CALC_WAIT.
- CALC_WAIT waits indefinitely for I_CALC_DONE.
REQ-024 SHALL, the cycle after I_CALC_DONE, enter WR_REQ.
- WR_REQ pulses O_BRAM_WR_ENA_PULSE for one cycle with O_BRAM_SEL = {2'b11, idx}, then goes to WR_WAIT.
REQ-025 SHALL, on I_BRAM_WR_DONE in WR_WAIT:
- if idx == latched count - 1, go to FIN;
- otherwise increment idx, reset mat to Q, and go to RD_REQ.
REQ-026 SHALL, in FIN, pulse O_DONE for one cycle and return to IDLE.
REQ-027 SHALL hold O_BRAM_SEL stable from each request cycle until the next request.
REQ-028 SHALL treat I_TILE_NUM == 0 at start as an empty run: go directly to FIN with no BRAM accesses.
REQ-029 SHALL ignore I_START while O_BUSY is high.
REQ-030 SHALL ignore I_BRAM_VLD, I_BRAM_WR_DONE and I_CALC_DONE outside their respective wait states.
REQ-031 SHALL, on I_ABORT in any state, enter IDLE next cycle with all pulses low and no O_DONE.
- I_ABORT wins over a simultaneous I_START.
REQ-032 SHALL never assert the read and write pulses in the same cycle.
REQ-033 SHALL never issue a request while a previous BRAM access is still outstanding.

Reset
REQ-034 SHALL, while I_RST_N is low, force state IDLE and all outputs to 0, including O_BRAM_SEL = 8'h00 and O_TILE_IDX = 0.
REQ-035 SHALL abandon any run in progress on reset mid-operation, with no O_DONE.
- After reset release, the block waits for a fresh I_START.

Structure
REQ-036 SHALL take the matrix-select constants (SEL_Q/K/V/O), the FSM state enum and the tile-index width from the shared package mha_pkg, shared with bram_manager.
REQ-037 SHALL be a single module with no sub-module.
- The Q/K/V counter and the tile counter are local registers.

Verification
REQ-038 Single tile: I_TILE_NUM = 1, bram model answers VLD 3 cycles after each read -> the bench SHALL check:
- reads with SEL 8'h00, 8'h40, 8'h80;
- O_LOAD_SEL 0, 1, 2;
- one O_CALC_START;
- after I_CALC_DONE, a write with SEL 8'hC0;
- O_DONE one cycle after WR_DONE.
REQ-039 Three tiles: I_TILE_NUM = 3 -> the bench SHALL check nine reads and three writes (SEL 8'hC0, 8'hC1, 8'hC2), then a single O_DONE, with O_BUSY high throughout.
REQ-040 Boundary counts -> the bench SHALL check:
- I_TILE_NUM = 0 gives O_DONE 2 cycles after I_START with no request pulses;
- I_TILE_NUM = 100 gives the last write at SEL 8'hFF.
REQ-041 Abort: I_ABORT asserted during CALC_WAIT of tile 1 -> the bench SHALL check IDLE next cycle, O_BUSY = 0, no write and no O_DONE; a later I_START restarts from tile 0.
REQ-042 Stray inputs: I_BRAM_VLD in CALC_WAIT, and I_START while busy -> the bench SHALL check that sequencing is unchanged.
REQ-043 Reset: I_RST_N dropped in RD_WAIT -> the bench SHALL check all outputs 0 immediately (asynchronous).
